// File: rtl/aud_rate_engine_if.sv
// SRAM read port and player-side signals of the playback-rate engine.
// The engine uses the master modport; the SRAM/player side uses the slave modport.
interface aud_rate_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              i_daclrck;
  logic [DATA_W-1:0] i_sram_data;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_dac_data;
  logic              o_player_en;
  logic              o_done;

  modport master (
    input  i_daclrck,
    input  i_sram_data,
    output o_sram_addr,
    output o_dac_data,
    output o_player_en,
    output o_done
  );

  modport slave (
    output i_daclrck,
    output i_sram_data,
    input  o_sram_addr,
    input  o_dac_data,
    input  o_player_en,
    input  o_done
  );
endinterface

// File: rtl/aud_rate_engine.sv
// Fractional-step playback engine: one SRAM-backed output sample per DAC frame.
// Define AUD_RATE_ENGINE_INTERP_EN for linear interpolation; default build is zero-order hold.
module aud_rate_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int INT_W  = 4,
  parameter int FRAC_W = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_pause,
  input  logic                    i_stop,
  input  logic                    i_reverse,
  input  logic [INT_W+FRAC_W-1:0] i_step,
  input  logic [ADDR_W-1:0]       i_start_addr,
  input  logic [ADDR_W-1:0]       i_end_addr,
  aud_rate_engine_if.master       bus
);
  localparam int POS_W  = ADDR_W + FRAC_W;
  localparam int STEP_W = INT_W + FRAC_W;
  localparam int PROD_W = DATA_W + FRAC_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FETCH0 = 3'd2,
    ST_FETCH1 = 3'd3,
    ST_CALC   = 3'd4,
    ST_PAUSE  = 3'd5
  } state_t;

  state_t            state_r;
  logic              lrck_prev_r;
  logic [POS_W-1:0]  pos_r;
  logic [STEP_W-1:0] step_r;
  logic              rev_r;
  logic [DATA_W-1:0] d0_r;
  logic [ADDR_W-1:0] sram_addr_r;
  logic [DATA_W-1:0] dac_data_r;
  logic              player_en_r;
  logic              done_r;

  logic              frame_edge_s;
  logic [ADDR_W-1:0] ia_s;
  logic [POS_W:0]    step_ext_s;
  logic [POS_W:0]    npos_s;
  logic [ADDR_W-1:0] nia_s;
  logic              clip_end_s;
  logic [DATA_W-1:0] sample_s;
  logic [ADDR_W-1:0] next_addr_s;

  assign frame_edge_s = lrck_prev_r & ~bus.i_daclrck;
  assign ia_s         = pos_r[POS_W-1:FRAC_W];

  // Extra top bit of npos_s holds the carry (forward) or borrow (reverse).
  assign step_ext_s = {{(POS_W+1-STEP_W){1'b0}}, step_r};
  assign npos_s     = rev_r ? ({1'b0, pos_r} - step_ext_s) : ({1'b0, pos_r} + step_ext_s);
  assign nia_s      = npos_s[POS_W-1:FRAC_W];
  assign clip_end_s = npos_s[POS_W] | (rev_r ? (nia_s < i_start_addr) : (nia_s > i_end_addr));

`ifdef AUD_RATE_ENGINE_INTERP_EN
  logic                     at_end_s;
  logic [DATA_W-1:0]        d1_s;
  logic [FRAC_W-1:0]        fr_s;
  logic signed [DATA_W:0]   diff_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] sum_s;
  logic [FRAC_W:0]          sum_unused_s;

  // At the last sample there is no right neighbour, so it interpolates with itself.
  assign at_end_s    = (ia_s == i_end_addr);
  assign next_addr_s = at_end_s ? ia_s : (ia_s + {{(ADDR_W-1){1'b0}}, 1'b1});
  assign d1_s        = at_end_s ? d0_r : bus.i_sram_data;
  assign fr_s        = pos_r[FRAC_W-1:0];
  assign diff_s      = $signed({d1_s[DATA_W-1], d1_s}) - $signed({d0_r[DATA_W-1], d0_r});
  assign prod_s      = $signed({{FRAC_W{diff_s[DATA_W]}}, diff_s})
                     * $signed({{(DATA_W+1){1'b0}}, fr_s});
  // Result always lies between d0 and d1, so dropping the top bits is exact.
  assign sum_s       = $signed({{(FRAC_W+1){d0_r[DATA_W-1]}}, d0_r}) + (prod_s >>> FRAC_W);
  assign {sum_unused_s, sample_s} = sum_s;
`else
  assign next_addr_s = ia_s;
  assign sample_s    = d0_r;
`endif

  assign bus.o_sram_addr = sram_addr_r;
  assign bus.o_dac_data  = dac_data_r;
  assign bus.o_player_en = player_en_r;
  assign bus.o_done      = done_r;

  // Frame sequencer, position datapath and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      lrck_prev_r <= 1'b1;
      pos_r       <= '0;
      step_r      <= '0;
      rev_r       <= 1'b0;
      d0_r        <= '0;
      sram_addr_r <= '0;
      dac_data_r  <= '0;
      player_en_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      lrck_prev_r <= bus.i_daclrck;
      done_r      <= 1'b0;
      if (i_stop) begin
        state_r     <= ST_IDLE;
        pos_r       <= '0;
        sram_addr_r <= '0;
        dac_data_r  <= '0;
        player_en_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            dac_data_r <= '0;
            if (i_start) begin
              pos_r       <= i_reverse ? {i_end_addr, {FRAC_W{1'b0}}} : {i_start_addr, {FRAC_W{1'b0}}};
              player_en_r <= 1'b1;
              state_r     <= ST_WAIT;
            end else begin
              player_en_r <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (frame_edge_s) begin
              step_r <= i_step;
              rev_r  <= i_reverse;
              if (i_pause) begin
                player_en_r <= 1'b0;
                state_r     <= ST_PAUSE;
              end else begin
                sram_addr_r <= ia_s;
                state_r     <= ST_FETCH0;
              end
            end else begin
              state_r <= ST_WAIT;
            end
          end
          ST_FETCH0: begin
            sram_addr_r <= next_addr_s;
            state_r     <= ST_FETCH1;
          end
          ST_FETCH1: begin
            d0_r    <= bus.i_sram_data;
            state_r <= ST_CALC;
          end
          ST_CALC: begin
            dac_data_r <= sample_s;
            if (clip_end_s) begin
              done_r      <= 1'b1;
              player_en_r <= 1'b0;
              pos_r       <= '0;
              state_r     <= ST_IDLE;
            end else begin
              pos_r   <= npos_s[POS_W-1:0];
              state_r <= ST_WAIT;
            end
          end
          ST_PAUSE: begin
            if (frame_edge_s && !i_pause) begin
              step_r      <= i_step;
              rev_r       <= i_reverse;
              player_en_r <= 1'b1;
              sram_addr_r <= ia_s;
              state_r     <= ST_FETCH0;
            end else begin
              state_r <= ST_PAUSE;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            player_en_r <= 1'b0;
            dac_data_r  <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aud_rate_engine.sv
// Self-checking bench for aud_rate_engine: directed vector table, hand sequences
// for pause/stop/reset, and randomized clips against a position-arithmetic model.
module tb_aud_rate_engine;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;
  localparam int INT_W  = 4;
  localparam int FRAC_W = 4;
`ifdef AUD_RATE_ENGINE_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic              i_reverse;
  logic [7:0]        i_step;
  logic [ADDR_W-1:0] i_start_addr;
  logic [ADDR_W-1:0] i_end_addr;

  aud_rate_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  aud_rate_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_pause      (i_pause),
    .i_stop       (i_stop),
    .i_reverse    (i_reverse),
    .i_step       (i_step),
    .i_start_addr (i_start_addr),
    .i_end_addr   (i_end_addr),
    .bus          (bus.master)
  );

  logic [15:0] mem [0:255];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 i_clk = ~i_clk;

  // SRAM model: data appears the cycle after the address is driven
  always @(posedge i_clk) bus.i_sram_data <= mem[bus.o_sram_addr[7:0]];

  typedef struct packed {
    int pat;
    int sa;
    int ea;
    int step;
    int rev;
    int n;
    int didx;
    logic [7:0][15:0] exp;
  } vec_t;

  vec_t tbl [9];

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int dac_val();
    return int'($signed(bus.o_dac_data));
  endfunction

  task automatic set_vec(input int i, pat, sa, ea, step, rev, n, didx,
                         input int e0, e1, e2, e3, e4, e5, e6, e7);
    vec_t v;
    v.pat = pat; v.sa = sa; v.ea = ea; v.step = step; v.rev = rev; v.n = n; v.didx = didx;
    v.exp[0] = e0[15:0]; v.exp[1] = e1[15:0]; v.exp[2] = e2[15:0]; v.exp[3] = e3[15:0];
    v.exp[4] = e4[15:0]; v.exp[5] = e5[15:0]; v.exp[6] = e6[15:0]; v.exp[7] = e7[15:0];
    tbl[i] = v;
  endtask

  task automatic load_pat(input int pat);
    for (int k = 0; k < 256; k++) begin
      int val;
      case (pat)
        0:       val = k * 10;
        1:       val = (k - 2) * 100;
        2:       val = k * 16;
        3:       val = -(k * 7);
        default: val = 0;
      endcase
      mem[k] = val[15:0];
    end
  endtask

  task automatic do_stop(input string tag);
    i_stop = 1'b1;
    tick;
    i_stop = 1'b0;
    check({tag, "_stop_dac"}, dac_val(), 0);
    check({tag, "_stop_en"}, int'(bus.o_player_en), 0);
    check({tag, "_stop_done"}, int'(bus.o_done), 0);
    tick;
  endtask

  // One DAC frame: edge at cycle E, sample address at E+1/E+2, output at E+4, aftermath at E+5.
  task automatic run_frame(input int step, input int rev, input int gap,
                           output int dac, output int done, output int a0, output int a1,
                           output int en5, output int dac5, output int done5);
    i_step         = step[7:0];
    i_reverse      = rev[0];
    bus.i_daclrck  = 1'b0;
    tick;
    a0 = int'(bus.o_sram_addr);
    bus.i_daclrck = 1'b1;
    i_step        = 8'($urandom);
    i_reverse     = 1'($urandom);
    tick;
    a1 = int'(bus.o_sram_addr);
    tick;
    tick;
    dac  = dac_val();
    done = int'(bus.o_done);
    tick;
    en5   = int'(bus.o_player_en);
    dac5  = dac_val();
    done5 = int'(bus.o_done);
    repeat (gap) tick;
  endtask

  task automatic start_clip(input int sa, input int ea, input int rev, input string tag);
    i_start_addr = 20'(sa);
    i_end_addr   = 20'(ea);
    i_reverse    = rev[0];
    i_start      = 1'b1;
    tick;
    i_start = 1'b0;
    check({tag, "_start_en"}, int'(bus.o_player_en), 1);
    tick;
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int dac, done, a0, a1, en5, dac5, done5;
    bit ended;
    string tag;
    tag   = $sformatf("v%0d", idx);
    ended = 1'b0;
    load_pat(v.pat);
    start_clip(v.sa, v.ea, v.rev, tag);
    for (int f = 0; f < v.n; f++) begin
      run_frame(v.step, v.rev, 1, dac, done, a0, a1, en5, dac5, done5);
      check($sformatf("%s_f%0d_dac", tag, f), dac, int'($signed(v.exp[f])));
      check($sformatf("%s_f%0d_done", tag, f), done, int'(f == v.didx));
      check($sformatf("%s_f%0d_bounds", tag, f),
            int'(a0 >= v.sa && a0 <= v.ea && a1 >= v.sa && a1 <= v.ea), 1);
      check($sformatf("%s_f%0d_pulse", tag, f), done5, 0);
      if (f == v.didx) begin
        check({tag, "_end_dac"}, dac5, 0);
        check({tag, "_end_en"}, en5, 0);
        ended = 1'b1;
        break;
      end
    end
    if (!ended) begin
      check({tag, "_run_en"}, int'(bus.o_player_en), 1);
      do_stop(tag);
    end
  endtask

  task automatic run_random(input int idx);
    int sa, ea, rev, p, np, ia, fr, d0, d1, q, expv, step, dac, done, a0, a1, en5, dac5, done5;
    bit fin;
    string tag;
    tag = $sformatf("r%0d", idx);
    for (int k = 0; k < 64; k++) mem[k] = 16'($urandom);
    sa  = int'($urandom_range(0, 40));
    ea  = sa + int'($urandom_range(0, 15));
    rev = int'($urandom_range(0, 1));
    start_clip(sa, ea, rev, tag);
    p   = (rev != 0) ? ea * 16 : sa * 16;
    fin = 1'b0;
    for (int f = 0; f < 10; f++) begin
      step = int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) rev = 1 - rev;
      ia = p / 16;
      fr = p % 16;
      d0 = int'($signed(mem[ia]));
      d1 = (ia == ea) ? d0 : int'($signed(mem[ia + 1]));
      q  = (d1 - d0) * fr;
      if (INTERP) expv = d0 + ((q >= 0) ? q / 16 : -((-q + 15) / 16));
      else        expv = d0;
      np  = (rev != 0) ? p - step : p + step;
      fin = (rev != 0) ? (np < 0 || np / 16 < sa) : (np / 16 > ea);
      run_frame(step, rev, int'($urandom_range(0, 3)), dac, done, a0, a1, en5, dac5, done5);
      check($sformatf("%s_f%0d_dac", tag, f), dac, expv);
      check($sformatf("%s_f%0d_done", tag, f), done, int'(fin));
      if (fin) begin
        check({tag, "_end_en"}, en5, 0);
        break;
      end
      p = np;
    end
    if (!fin) do_stop(tag);
  endtask

  initial begin
    int dac, done, a0, a1, en5, dac5, done5;
    i_rst_n = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0; i_reverse = 1'b0;
    i_step = 8'h10; i_start_addr = '0; i_end_addr = '0;
    bus.i_daclrck = 1'b1;
    load_pat(0);
    repeat (3) tick;
    check("rst_dac", dac_val(), 0);
    check("rst_en", int'(bus.o_player_en), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_addr", int'(bus.o_sram_addr), 0);
    i_rst_n = 1'b1;
    tick;

    // start while stop is high: stop wins
    i_start = 1'b1; i_stop = 1'b1;
    tick;
    i_start = 1'b0; i_stop = 1'b0;
    check("start_vs_stop_en", int'(bus.o_player_en), 0);
    tick;
    check("start_vs_stop_en2", int'(bus.o_player_en), 0);

    set_vec(0, 0, 0, 7, 16'h10, 0, 8, 7, 0, 10, 20, 30, 40, 50, 60, 70);
    if (INTERP) set_vec(1, 1, 3, 4, 16'h04, 0, 8, 7, 100, 125, 150, 175, 200, 200, 200, 200);
    else        set_vec(1, 1, 3, 4, 16'h04, 0, 8, 7, 100, 100, 100, 100, 200, 200, 200, 200);
    if (INTERP) set_vec(2, 2, 0, 5, 16'h18, 0, 4, 3, 0, 24, 48, 72, 0, 0, 0, 0);
    else        set_vec(2, 2, 0, 5, 16'h18, 0, 4, 3, 0, 16, 48, 64, 0, 0, 0, 0);
    set_vec(3, 0, 2, 5, 16'h10, 1, 4, 3, 50, 40, 30, 20, 0, 0, 0, 0);
    set_vec(4, 0, 2, 6, 16'h00, 0, 4, -1, 20, 20, 20, 20, 0, 0, 0, 0);
    set_vec(5, 0, 20'hFFFFE, 20'hFFFFF, 16'hF0, 0, 1, 0, 2540, 0, 0, 0, 0, 0, 0, 0);
    set_vec(6, 0, 0, 1, 16'h18, 1, 1, 0, 10, 0, 0, 0, 0, 0, 0, 0);
    if (INTERP) set_vec(7, 0, 0, 3, 16'h08, 1, 7, 6, 30, 25, 20, 15, 10, 5, 0, 0);
    else        set_vec(7, 0, 0, 3, 16'h08, 1, 7, 6, 30, 20, 20, 10, 10, 0, 0, 0);
    if (INTERP) set_vec(8, 3, 0, 1, 16'h05, 0, 7, 6, 0, -3, -5, -7, -7, -7, -7, 0);
    else        set_vec(8, 3, 0, 1, 16'h05, 0, 7, 6, 0, 0, 0, 0, -7, -7, -7, 0);

    for (int i = 0; i < 9; i++) run_case(i, tbl[i]);

    // pause requested during CALC: frame completes, then output holds until release
    load_pat(0);
    start_clip(0, 7, 0, "pause");
    run_frame(16'h10, 0, 1, dac, done, a0, a1, en5, dac5, done5);
    check("pause_f0_dac", dac, 0);
    i_step = 8'h10; i_reverse = 1'b0;
    bus.i_daclrck = 1'b0; tick; bus.i_daclrck = 1'b1;
    tick; tick;
    i_pause = 1'b1;
    tick;
    check("pause_f1_dac", dac_val(), 10);
    check("pause_f1_en", int'(bus.o_player_en), 1);
    tick;
    i_step = 8'h10; i_reverse = 1'b0;
    bus.i_daclrck = 1'b0; tick; bus.i_daclrck = 1'b1;
    check("pause_enter_en", int'(bus.o_player_en), 0);
    repeat (4) tick;
    bus.i_daclrck = 1'b0; tick; bus.i_daclrck = 1'b1;
    repeat (4) tick;
    check("pause_hold_en", int'(bus.o_player_en), 0);
    check("pause_hold_dac", dac_val(), 10);
    i_pause = 1'b0;
    tick; tick;
    check("pause_release_wait_en", int'(bus.o_player_en), 0);
    i_step = 8'h10; i_reverse = 1'b0;
    bus.i_daclrck = 1'b0; tick; bus.i_daclrck = 1'b1;
    check("resume_en", int'(bus.o_player_en), 1);
    tick; tick; tick;
    check("resume_dac", dac_val(), 20);
    tick;
    do_stop("pause");

    // stop during FETCH1
    load_pat(0);
    start_clip(3, 7, 0, "stopf1");
    run_frame(16'h10, 0, 1, dac, done, a0, a1, en5, dac5, done5);
    check("stopf1_f0_dac", dac, 30);
    i_step = 8'h10; i_reverse = 1'b0;
    bus.i_daclrck = 1'b0; tick; bus.i_daclrck = 1'b1;
    tick;
    i_stop = 1'b1;
    tick;
    i_stop = 1'b0;
    check("stopf1_dac", dac_val(), 0);
    check("stopf1_en", int'(bus.o_player_en), 0);
    check("stopf1_addr", int'(bus.o_sram_addr), 0);
    check("stopf1_done", int'(bus.o_done), 0);
    repeat (4) tick;
    check("stopf1_no_done", int'(bus.o_done), 0);

    // async reset during CALC
    start_clip(3, 7, 0, "rstcalc");
    run_frame(16'h10, 0, 1, dac, done, a0, a1, en5, dac5, done5);
    check("rstcalc_f0_dac", dac, 30);
    i_step = 8'h10; i_reverse = 1'b0;
    bus.i_daclrck = 1'b0; tick; bus.i_daclrck = 1'b1;
    tick; tick;
    i_rst_n = 1'b0;
    #1;
    check("rstcalc_dac", dac_val(), 0);
    check("rstcalc_en", int'(bus.o_player_en), 0);
    check("rstcalc_done", int'(bus.o_done), 0);
    tick;
    i_rst_n = 1'b1;
    repeat (3) tick;
    check("rstcalc_no_done", int'(bus.o_done), 0);
    check("rstcalc_idle_en", int'(bus.o_player_en), 0);

    for (int i = 0; i < 30; i++) run_random(i);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/aud_rate_engine.md
Name: aud_rate_engine

Overview:
- Parametrised playback-rate engine between the SRAM sample store and the audio player.
- Once per DAC frame (falling edge of i_daclrck) it:
  - fetches one or two samples,
  - produces one output sample,
  - advances a fixed-point position by a programmable step, forward or reverse.
- Generalises fast/slow/reverse playback into one fractional-step engine with true linear interpolation (no divider) and programmable start/end bounds with end-of-clip detection.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- ADDR_W, 20, SRAM word-address width.
- INT_W, 4, integer bits of the step.
- FRAC_W, 4, fractional bits of the step and of the position.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  level; begin playback from IDLE.
- i_pause  in  1  level; pause at next frame boundary.
- i_stop  in  1  level; abort to IDLE.
- i_reverse  in  1  direction, sampled at each frame edge.
- i_step  in  INT_W+FRAC_W  unsigned step, Q(INT_W).(FRAC_W); 1<<FRAC_W = normal speed.
- i_daclrck  in  1  DAC LR clock.
- i_start_addr  in  ADDR_W  first valid sample.
- i_end_addr  in  ADDR_W  last valid sample (>= i_start_addr).
- i_sram_data  in  DATA_W  read data; valid the cycle after o_sram_addr is driven.
- o_sram_addr  out  ADDR_W  read address.
- o_dac_data  out  DATA_W  output sample to player.
- o_player_en  out  1  player enable.
- o_done  out  1  one-cycle pulse at end of clip.

Behaviour:
- Reset (async): state IDLE, pos=0, o_sram_addr=0, o_dac_data=0, o_player_en=0, o_done=0, lrck_prev=1.
- pos register: ADDR_W+FRAC_W bits. Integer part ia = pos[ADDR_W+FRAC_W-1:FRAC_W]; fraction fr = pos[FRAC_W-1:0].
- Frame edge: lrck_prev==1 and i_daclrck==0. lrck_prev is updated every cycle.
- Priority every cycle: i_stop > i_pause > everything else. i_stop in any state -> IDLE next cycle; o_dac_data=0, o_player_en=0, pos=0, no o_done.
- States:
  - IDLE: i_start -> WAIT. Load pos = i_reverse ? {i_end_addr,0} : {i_start_addr,0}. o_player_en=1 from WAIT onward.
  - WAIT: on frame edge latch step/dir; then i_pause -> PAUSE, else -> FETCH0. o_dac_data holds.
  - FETCH0: o_sram_addr=ia -> FETCH1.
  - FETCH1: capture d0=i_sram_data; o_sram_addr = (ia==i_end_addr) ? ia : ia+1 -> CALC.
  - CALC: capture d1 (d1=d0 if ia==i_end_addr); register o_dac_data; advance pos -> WAIT, or IDLE on end.
  - PAUSE: o_player_en=0, o_dac_data and pos held. On frame edge with i_pause low -> FETCH0, o_player_en=1.
- Latency: o_dac_data updates 3 cycles after the frame-edge cycle (edge=E, FETCH0 E+1, FETCH1 E+2, CALC E+3, visible E+4). Output held constant until the next update.
- Interpolation: diff = d1-d0 (DATA_W+1 signed); prod = diff*fr (DATA_W+FRAC_W+1 signed); out = d0 + (prod >>> FRAC_W), arithmetic shift, rounds toward −inf. The result always lies in [min(d0,d1), max(d0,d1)], so no saturation is needed.
- Advance: computed in ADDR_W+FRAC_W+1 bits.
  - Forward: npos = pos+step; end when carry or npos.ia > i_end_addr.
  - Reverse: npos = pos−step; end when borrow or npos.ia < i_start_addr.
  - On end: o_done=1 for one cycle, state IDLE, o_player_en=0, o_dac_data=0 on the following cycle. The last in-range sample is still output.
- step=0: position frozen; the same sample is output each frame, never ends.
- i_step or i_reverse changes mid-frame take effect at the next frame edge only.
- i_start outside IDLE is ignored. i_start with i_stop high: stop wins.

Optional Feature:
- AUD_RATE_ENGINE_INTERP_EN
  - Defined: linear interpolation as above, FETCH1 fetch of ia+1 performed.
  - Undefined: zero-order hold, o_dac_data=d0. FETCH1 drives no new address; d1 is unused. Cycle timing is unchanged (E+4) so the player interface is identical.

Test Plan:
- SRAM[k]=k*10, start=0, end=7, step=0x10, forward -> o_dac_data 0,10,20,...,70 on successive frames; o_done pulses one cycle after the 70 frame; o_player_en drops to 0.
- SRAM[3]=100, SRAM[4]=200, pos=3.0, step=0x04 -> outputs 100,125,150,175,200. Without the macro -> 100,100,100,100,200.
- step=0x18 (1.5) from addr 0, SRAM[k]=k*16 -> 0,24,48,72 (positions 0,1.5,3,4.5).
- Reverse, start=2, end=5, step=0x10 -> SRAM[5],[4],[3],[2], then o_done; no read below address 2.
- i_pause asserted during CALC -> that frame completes, then PAUSE, o_player_en=0, output held. Release -> resumes at the next frame edge with the next position.
- i_stop during FETCH1, and i_rst_n low during CALC -> IDLE next cycle (async for reset); all outputs 0; no o_done pulse.
